yarvi_runctl: RTL and testbench
===============================

# yarvi_runctl

Run-control sequencer for the yarvi core: it owns the core's `freeze` input and sequences halt, resume and single-step from a debug/loader command port. It watches the memory-stage retire stream (`me_valid`, `me_pc`) to drain the pipeline, count retired instructions and detect a PC breakpoint. It sits beside `yarvi` at the SoC top level, between the debug host/loader and the core.

## Interface
Parameters:
- `VW`, 32: PC width; must equal the core's `VMSB+1`.
- `CNT_W`, 32: retire counter width.
- `DRAIN`, 2: consecutive idle frozen cycles (no retire) needed to declare the core halted; valid range 1..15.
- `START_HALTED`, 0: 1 selects the halted state after reset, so a loader can fill memory first.

Ports:
- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command strobe.
- `cmd_op`  in  2  command: 0 HALT, 1 RESUME, 2 STEP, 3 CLRCNT.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `bp_we`  in  1  breakpoint register write strobe.
- `bp_en_in`  in  1  breakpoint enable, written on `bp_we`.
- `bp_pc_in`  in  VW  breakpoint PC, written on `bp_we`.
- `me_valid`  in  1  core retire strobe.
- `me_pc`  in  VW  PC of the retiring instruction.
- `freeze`  out  1  registered; drives `yarvi.freeze`.
- `halted`  out  1  registered; core is frozen and drained.
- `halt_cause`  out  2  registered: 0 none, 1 command, 2 breakpoint, 3 step.
- `retire_count`  out  CNT_W  registered count of `me_valid` cycles.

## Operation
- States: RUN, HALTING, HALTED, STEPPING.
- `cmd_ready` is 1 in RUN and HALTED and 0 in HALTING and STEPPING. Legal commands that are not meaningful in the current state are accepted and ignored: RESUME or STEP in RUN, HALT in HALTED.
- **RUN**
  - HALT: go to HALTING and set cause 1.
  - Breakpoint hit (`me_valid & bp_en & me_pc==bp_pc`): go to HALTING and set cause 2.
- **HALTING**
  - `freeze`=1.
  - The drain counter increments on each cycle with `me_valid`=0 and clears on each cycle with `me_valid`=1. Retires during drain are counted normally.
  - When the counter reaches DRAIN, go to HALTED.
- **HALTED**
  - `freeze`=1 and `halted`=1.
  - RESUME: go to RUN and set cause 0.
  - STEP: go to STEPPING.
- **STEPPING**
  - `freeze`=0.
  - On the first `me_valid`: go to HALTING and set cause 3.
  - Breakpoint compare is ignored in this state.
  - There is no timeout; reset is the only exit if no instruction retires.
- CLRCNT is accepted in RUN or HALTED and zeroes `retire_count`. If a retire occurs in the same cycle, the count becomes 1.
- `retire_count` adds 1 on every `me_valid`, in any state, and wraps modulo 2^CNT_W.
- `bp_we` may be written in any state; the new value is used from the next cycle.
- The breakpoint instruction itself retires and is counted before the core halts. Instructions already in flight may still retire during HALTING.

## Timing
- Reset values with `START_HALTED`=0: state RUN, `freeze`=0, `halted`=0, cause 0, count 0, `bp_en`=0, `bp_pc`=0.
- Reset values with `START_HALTED`=1: state HALTED, `freeze`=1, `halted`=1, cause 1; other values as above.
- A reset asserted mid-operation returns to these values on the next edge, regardless of state.
- HALT accepted in cycle t: `freeze`=1 at t+1. The earliest `halted`=1 is at t+1+DRAIN, when no retires occur.
- Breakpoint match in cycle t: `freeze`=1 at t+1, with the same drain rule.
- RESUME accepted at t: `freeze`=0 and `halted`=0 at t+1.
- STEP accepted at t: `freeze`=0 and `halted`=0 at t+1. Retire at r: `freeze`=1 at r+1, then drain.
- HALT and breakpoint hit in the same RUN cycle: cause is 2.
- `halt_cause` changes in the same cycle as the state change that sets it.

## Configuration
- Macro: `YARVI_BREAKPOINT_EN`.
- Defined: breakpoint registers and comparator are built as described above.
- Undefined:
  - `bp_*` ports remain but are ignored.
  - No breakpoint registers are built.
  - Cause 2 is never produced.
  - All other behaviour is identical.

## Test plan
- Reset with `START_HALTED`=0 and DRAIN=2; `me_valid` pulses on 5 cycles; HALT at cycle 10 with no retires afterwards -> `freeze`=1 at 11, `halted`=1 at 13, cause 1, count 5.
- From HALTED, STEP; `me_valid` held 0 for 3 cycles, then 1 for 1 cycle -> `freeze` low for 4 cycles and high on the cycle after the retire, `halted`=1 DRAIN cycles later, cause 3, count +1.
- With `YARVI_BREAKPOINT_EN`: write `bp_pc_in`=0x80000010 with `bp_en_in`=1; retire PCs 0x80000000, 0x80000004, …, 0x80000010 -> `freeze`=1 the cycle after the 0x80000010 retire, cause 2. Same stimulus without the macro -> no halt.
- During HALTING, `me_valid` at drain counts 0, 1, 0 -> the drain restarts each time; `halted` asserts only after 2 consecutive idle cycles, and the count includes those retires.
- Preload `retire_count`=2^32−1 via 2^32−1 retires (a forced-state shortcut is acceptable), then one more retire -> count 0. CLRCNT in the same cycle as a retire -> count 1.
- Reset asserted while STEPPING -> next cycle state RUN, `freeze`=0, count 0, `bp_en`=0; `cmd_ready`=1.

Source files
------------

// File: rtl/yarvi_runctl.sv
// yarvi_runctl: run-control sequencer for the yarvi core.
// Owns the core freeze line and sequences halt, resume and single-step
// from a command port. It also drains the pipeline, counts retired
// instructions, and optionally halts on a PC breakpoint.
// Build option: define YARVI_BREAKPOINT_EN to build the breakpoint
// registers and comparator. When it is undefined, the bp_* ports are ignored.
module yarvi_runctl #(
  parameter int VW           = 32,
  parameter int CNT_W        = 32,
  parameter int DRAIN        = 2,
  parameter bit START_HALTED = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             bp_we,
  input  logic             bp_en_in,
  input  logic [VW-1:0]    bp_pc_in,
  input  logic             me_valid,
  input  logic [VW-1:0]    me_pc,
  output logic             freeze,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {RUN, HALTING, HALTED, STEPPING} state_t;

  localparam logic [1:0] OP_HALT   = 2'd0;
  localparam logic [1:0] OP_RESUME = 2'd1;
  localparam logic [1:0] OP_STEP   = 2'd2;
  localparam logic [1:0] OP_CLRCNT = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_CMD  = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  // Halted is declared on the idle cycle that brings the count to DRAIN.
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       cmd_fire;
  logic       bp_hit;

  assign cmd_fire = cmd_valid & cmd_ready;

`ifdef YARVI_BREAKPOINT_EN
  logic          bp_en;
  logic [VW-1:0] bp_pc;

  // Breakpoint register: a write takes effect from the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      bp_en <= 1'b0;
      bp_pc <= '0;
    end else if (bp_we) begin
      bp_en <= bp_en_in;
      bp_pc <= bp_pc_in;
    end
  end

  assign bp_hit = me_valid & bp_en & (me_pc == bp_pc);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_we, bp_en_in, bp_pc_in, me_pc};
  assign bp_hit    = 1'b0;
`endif

  // Run-control FSM. All outputs are registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= START_HALTED ? HALTED : RUN;
      freeze     <= START_HALTED;
      halted     <= START_HALTED;
      halt_cause <= START_HALTED ? CAUSE_CMD : CAUSE_NONE;
      cmd_ready  <= 1'b1;
      drain_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          drain_cnt <= '0;
          // A breakpoint outranks a simultaneous HALT command for the cause.
          if (bp_hit) begin
            state      <= HALTING;
            freeze     <= 1'b1;
            cmd_ready  <= 1'b0;
            halt_cause <= CAUSE_BP;
          end else if (cmd_fire && cmd_op == OP_HALT) begin
            state      <= HALTING;
            freeze     <= 1'b1;
            cmd_ready  <= 1'b0;
            halt_cause <= CAUSE_CMD;
          end
        end
        HALTING: begin
          // A retire restarts the count of consecutive idle frozen cycles.
          if (me_valid) begin
            drain_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state     <= HALTED;
            halted    <= 1'b1;
            cmd_ready <= 1'b1;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        HALTED: begin
          if (cmd_fire && cmd_op == OP_RESUME) begin
            state      <= RUN;
            freeze     <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= CAUSE_NONE;
          end else if (cmd_fire && cmd_op == OP_STEP) begin
            state     <= STEPPING;
            freeze    <= 1'b0;
            halted    <= 1'b0;
            cmd_ready <= 1'b0;
          end
        end
        STEPPING: begin
          // Breakpoints are ignored here; the first retire ends the step.
          if (me_valid) begin
            state      <= HALTING;
            freeze     <= 1'b1;
            halt_cause <= CAUSE_STEP;
            drain_cnt  <= '0;
          end
        end
        default: begin
          state     <= RUN;
          freeze    <= 1'b0;
          halted    <= 1'b0;
          cmd_ready <= 1'b1;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Retire counter: counts every retire in any state. A clear that lands
  // in the same cycle as a retire leaves that retire counted.
  always_ff @(posedge clock) begin
    if (reset)
      retire_count <= '0;
    else if (cmd_fire && cmd_op == OP_CLRCNT)
      retire_count <= me_valid ? CNT_W'(1) : '0;
    else if (me_valid)
      retire_count <= retire_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_yarvi_runctl.sv
// Directed testbench for yarvi_runctl.
// u0 uses the default configuration: DRAIN=2, 32-bit count, starts running.
// u1 uses a 4-bit count and START_HALTED=1, so wrap and halted-reset can be checked.
module tb_yarvi_runctl;
  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        bp_we;
  logic        bp_en_in;
  logic [31:0] bp_pc_in;
  logic        me_valid;
  logic [31:0] me_pc;
  logic        freeze;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] retire_count;

  logic        me_valid1;
  logic        cmd_ready1;
  logic        freeze1;
  logic        halted1;
  logic [1:0]  halt_cause1;
  logic [3:0]  retire_count1;

  int checks = 0;
  int errors = 0;
  logic exp_bp;

  always #5 clock = ~clock;

  yarvi_runctl u0 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .bp_we(bp_we), .bp_en_in(bp_en_in), .bp_pc_in(bp_pc_in),
    .me_valid(me_valid), .me_pc(me_pc), .freeze(freeze), .halted(halted),
    .halt_cause(halt_cause), .retire_count(retire_count)
  );

  yarvi_runctl #(.CNT_W(4), .START_HALTED(1'b1)) u1 (
    .clock(clock), .reset(reset), .cmd_valid(1'b0), .cmd_op(2'd0),
    .cmd_ready(cmd_ready1), .bp_we(1'b0), .bp_en_in(1'b0), .bp_pc_in(32'd0),
    .me_valid(me_valid1), .me_pc(32'd0), .freeze(freeze1), .halted(halted1),
    .halt_cause(halt_cause1), .retire_count(retire_count1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a command for one cycle.
  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (freeze !== 1'b0)    begin errors++; $display("FAIL rst_freeze got %0b exp 0", freeze); end
    checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL rst_halted got %0b exp 0", halted); end
    checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL rst_cause got %0d exp 0", halt_cause); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", retire_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", cmd_ready); end
    checks++; if ({freeze1, halted1, halt_cause1} !== 4'b1101)
      begin errors++; $display("FAIL rst_start_halted got %b exp 1101", {freeze1, halted1, halt_cause1}); end
    // A RESUME issued while running is accepted and ignored.
    cmd(2'd1);
    checks++; if ({freeze, cmd_ready} !== 2'b01)
      begin errors++; $display("FAIL resume_in_run got %b exp 01", {freeze, cmd_ready}); end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 5; i++) begin
      me_valid = 1'b1; tick();
      me_valid = 1'b0; tick();
    end
    cmd(2'd0);  // halt accepted; this is now cycle t+1
    checks++; if ({freeze, halted, cmd_ready} !== 3'b100)
      begin errors++; $display("FAIL halt_t1 got %b exp 100", {freeze, halted, cmd_ready}); end
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_t2 got %0b exp 0", halted); end
    tick();
    checks++; if ({halted, cmd_ready, halt_cause} !== 4'b1101)
      begin errors++; $display("FAIL halt_t3 got %b exp 1101", {halted, cmd_ready, halt_cause}); end
    chk("halt_count", retire_count, 32'd5);
    cmd(2'd0);  // a HALT issued while halted is ignored
    checks++; if ({freeze, halted} !== 2'b11)
      begin errors++; $display("FAIL halt_in_halted got %b exp 11", {freeze, halted}); end
  endtask

  task automatic test_step();
    cmd(2'd2);
    checks++; if ({freeze, halted, cmd_ready} !== 3'b000)
      begin errors++; $display("FAIL step_t1 got %b exp 000", {freeze, halted, cmd_ready}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL step_idle%0d got %0b exp 0", i, freeze); end
    end
    me_valid = 1'b1; tick(); me_valid = 1'b0;
    checks++; if ({freeze, halt_cause} !== 3'b111)
      begin errors++; $display("FAIL step_retire got %b exp 111", {freeze, halt_cause}); end
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step_drain1 got %0b exp 0", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_drain2 got %0b exp 1", halted); end
    chk("step_count", retire_count, 32'd6);
  endtask

  task automatic test_drain();
    logic mv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic hx [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cmd(2'd1);
    checks++; if ({freeze, halted, halt_cause} !== 4'b0000)
      begin errors++; $display("FAIL resume got %b exp 0000", {freeze, halted, halt_cause}); end
    cmd(2'd0);
    for (int i = 0; i < 5; i++) begin
      me_valid = mv[i]; tick();
      checks++; if (halted !== hx[i])
        begin errors++; $display("FAIL drain%0d got %0b exp %0b", i, halted, hx[i]); end
    end
    me_valid = 1'b0;
    chk("drain_count", retire_count, 32'd8);
  endtask

  task automatic test_breakpoint();
`ifdef YARVI_BREAKPOINT_EN
    exp_bp = 1'b1;
`else
    exp_bp = 1'b0;
`endif
    cmd(2'd1);
    bp_we = 1'b1; bp_en_in = 1'b1; bp_pc_in = 32'h8000_0010;
    tick();
    bp_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      me_valid = 1'b1; me_pc = 32'h8000_0000 + 32'(4 * i);
      tick();
    end
    me_valid = 1'b0;
    checks++; if ({freeze, halt_cause} !== {exp_bp, exp_bp, 1'b0})
      begin errors++; $display("FAIL bp_hit got %b exp %b", {freeze, halt_cause}, {exp_bp, exp_bp, 1'b0}); end
    chk("bp_count", retire_count, 32'd13);
`ifdef YARVI_BREAKPOINT_EN
    tick(); tick();
    cmd(2'd1);
`endif
    // A HALT command and a breakpoint hit arrive in the same cycle.
    cmd_valid = 1'b1; cmd_op = 2'd0; me_valid = 1'b1; me_pc = 32'h8000_0010;
    tick();
    cmd_valid = 1'b0; me_valid = 1'b0;
    checks++; if ({freeze, halt_cause} !== {1'b1, exp_bp, ~exp_bp})
      begin errors++; $display("FAIL bp_vs_halt got %b exp %b", {freeze, halt_cause}, {1'b1, exp_bp, ~exp_bp}); end
    tick(); tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted got %0b exp 1", halted); end
    chk("bp_count2", retire_count, 32'd14);
  endtask

  task automatic test_clrcnt();
    cmd_valid = 1'b1; cmd_op = 2'd3; me_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; me_valid = 1'b0;
    chk("clr_with_retire", retire_count, 32'd1);
    cmd(2'd3);
    chk("clr_plain", retire_count, 32'd0);
  endtask

  task automatic test_wrap();
    me_valid1 = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (retire_count1 !== 4'hf) begin errors++; $display("FAIL wrap_max got %0h exp f", retire_count1); end
    tick();
    me_valid1 = 1'b0;
    checks++; if (retire_count1 !== 4'h0) begin errors++; $display("FAIL wrap_zero got %0h exp 0", retire_count1); end
    checks++; if (halted1 !== 1'b1) begin errors++; $display("FAIL wrap_halted got %0b exp 1", halted1); end
  endtask

  task automatic test_reset_stepping();
    cmd(2'd2);
    checks++; if ({freeze, cmd_ready} !== 2'b00)
      begin errors++; $display("FAIL stepping got %b exp 00", {freeze, cmd_ready}); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if ({freeze, halted, cmd_ready, halt_cause} !== 5'b00100)
      begin errors++; $display("FAIL rst_step got %b exp 00100", {freeze, halted, cmd_ready, halt_cause}); end
    chk("rst_step_count", retire_count, 32'd0);
    // The breakpoint enable was cleared, so a retire at the old PC must not halt.
    me_valid = 1'b1; me_pc = 32'h8000_0010; tick(); me_valid = 1'b0;
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_bp_cleared got %0b exp 0", freeze); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    bp_we = 1'b0; bp_en_in = 1'b0; bp_pc_in = 32'd0;
    me_valid = 1'b0; me_pc = 32'd0; me_valid1 = 1'b0;
    exp_bp = 1'b0;
    test_reset();
    test_halt();
    test_step();
    test_drain();
    test_breakpoint();
    test_clrcnt();
    test_wrap();
    test_reset_stepping();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
